multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle MIPS main controller. Sequences the shared datapath (one memory, one ALU,
//  IR, PC) through FETCH/DECODE/EXEC/MEM/WB steps for R-type, lw, sw and beq.

---
 rtl/multicycle_ctrl_fsm.sv | 156 +++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB over a shared datapath.
// Optional jump support is compiled in with `define J_INSTR_EN.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP_CODE,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic       BusError,
  output logic       IllegalOp
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB = 4'd4,
    MEMWR  = 4'd5, EXEC   = 4'd6, ALUWB  = 4'd7, BRANCH = 4'd8, JUMP  = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             waiting, timeout, entering;

  assign waiting  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timeout  = waiting && !MemReady && (cnt == TMO);
  assign entering = (nxt != state || timeout) &&
                    ((nxt == FETCH) || (nxt == MEMRD) || (nxt == MEMWR));

  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:  nxt = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (OP_CODE)
          OP_RTYPE:     nxt = EXEC;
          OP_LW, OP_SW: nxt = MEMADR;
          OP_BEQ:       nxt = BRANCH;
`ifdef J_INSTR_EN
          OP_J:         nxt = JUMP;
`endif
          default:      nxt = FETCH;
        endcase
      end
      MEMADR: nxt = (OP_CODE == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = MemReady ? MEMWB : MEMRD;
      MEMWR:  nxt = MemReady ? FETCH : MEMWR;
      EXEC:   nxt = ALUWB;
      default: nxt = FETCH;
    endcase
    // A timed-out access abandons the instruction and refetches from the unchanged PC
    if (timeout) nxt = FETCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (entering || MemReady || !waiting) cnt <= '0;
      else                                  cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; IRWrite = 1'b0; MemtoReg = 1'b0; RegDst = 1'b0;
    RegWrite = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 2'b00; ALUOp = 2'b00;
    PCSource = 2'b00; InstrDone = 1'b0; BusError = 1'b0; IllegalOp = 1'b0;
    if (!rst) begin
      BusError = timeout;
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          case (OP_CODE)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ: IllegalOp = 1'b0;
`ifdef J_INSTR_EN
            OP_J:    IllegalOp = 1'b0;
`endif
            default: IllegalOp = 1'b1;
          endcase
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          MemtoReg  = 1'b1;
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        MEMWR: begin
          IorD      = 1'b1;
          MemWrite  = !timeout;
          InstrDone = MemReady;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        ALUWB: begin
          RegDst    = 1'b1;
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          InstrDone   = 1'b1;
        end
`ifdef J_INSTR_EN
        JUMP: begin
          PCWrite   = 1'b1;
          PCSource  = 2'b10;
          InstrDone = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Cycle-level scoreboard bench for multicycle_ctrl_fsm: each driven cycle queues the
// expected output vector, which is popped and compared at the following falling edge.
module tb_multicycle_ctrl_fsm;

  logic       clk, rst, MemReady;
  logic [5:0] OP_CODE;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic       RegDst, RegWrite, ALUSrcA, InstrDone, BusError, IllegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSource;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .OP_CODE(OP_CODE), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .InstrDone(InstrDone), .BusError(BusError), .IllegalOp(IllegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector bit positions
  localparam logic [18:0] PCW  = 19'd1 << 18, PCWC = 19'd1 << 17, IORD = 19'd1 << 16;
  localparam logic [18:0] MRD  = 19'd1 << 15, MWR  = 19'd1 << 14, IRW  = 19'd1 << 13;
  localparam logic [18:0] M2R  = 19'd1 << 12, RDST = 19'd1 << 11, RW   = 19'd1 << 10;
  localparam logic [18:0] SRCA = 19'd1 << 9;
  localparam logic [18:0] SB_4 = 19'd1 << 7, SB_IMM = 19'd2 << 7, SB_BR = 19'd3 << 7;
  localparam logic [18:0] OP_SUB = 19'd1 << 5, OP_FN = 19'd2 << 5;
  localparam logic [18:0] PS_OUT = 19'd1 << 3, PS_J = 19'd2 << 3;
  localparam logic [18:0] DONE = 19'd1 << 2, BERR = 19'd1 << 1, ILL = 19'd1;

  localparam logic [18:0] E_RST   = 19'd0;
  localparam logic [18:0] E_FW    = MRD | SB_4;
  localparam logic [18:0] E_FOK   = MRD | SB_4 | IRW | PCW;
  localparam logic [18:0] E_FTO   = MRD | SB_4 | BERR;
  localparam logic [18:0] E_DEC   = SB_BR;
  localparam logic [18:0] E_DILL  = SB_BR | ILL;
  localparam logic [18:0] E_MADR  = SRCA | SB_IMM;
  localparam logic [18:0] E_MRD   = MRD | IORD;
  localparam logic [18:0] E_MWB   = M2R | RW | DONE;
  localparam logic [18:0] E_MWRW  = MWR | IORD;
  localparam logic [18:0] E_MWRD  = MWR | IORD | DONE;
  localparam logic [18:0] E_MWRTO = IORD | BERR;
  localparam logic [18:0] E_EXEC  = SRCA | OP_FN;
  localparam logic [18:0] E_ALUWB = RDST | RW | DONE;
  localparam logic [18:0] E_BR    = SRCA | OP_SUB | PCWC | PS_OUT | DONE;
  localparam logic [18:0] E_JMP   = PCW | PS_J | DONE;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, JOP = 6'b000010, BAD = 6'b111111;

  typedef struct {
    string       tag;
    logic [18:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0, n_err = 0;
  logic [18:0] outv;

  assign outv = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                 InstrDone, BusError, IllegalOp};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic m,
                      input logic [5:0] op, input logic [18:0] e);
    sb_t it;
    @(posedge clk);
    #1;
    rst = r; MemReady = m; OP_CODE = op;
    it.tag = tag; it.exp = e;
    sb.push_back(it);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t it;
      it = sb.pop_front();
      chk(it.tag, {13'd0, outv}, {13'd0, it.exp});
    end
  end

  initial begin
    rst = 1'b1; MemReady = 1'b1; OP_CODE = RT;
    // Reset holds every output low even with MemReady asserted
    step("rst0", 1, 1, RT, E_RST);
    step("rst1", 1, 1, RT, E_RST);

    // add; MemReady in non-wait states must be ignored
    step("add_f",   0, 1, RT, E_FOK);
    step("add_d",   0, 1, RT, E_DEC);
    step("add_ex",  0, 1, RT, E_EXEC);
    step("add_wb",  0, 1, RT, E_ALUWB);

    // lw with three wait cycles in MEMRD
    step("lw_f",    0, 1, LW, E_FOK);
    step("lw_d",    0, 0, LW, E_DEC);
    step("lw_adr",  0, 0, LW, E_MADR);
    for (int i = 0; i < 3; i++) step("lw_wait", 0, 0, LW, E_MRD);
    step("lw_rd",   0, 1, LW, E_MRD);
    step("lw_wb",   0, 0, LW, E_MWB);

    // sw with two wait cycles in MEMWR
    step("sw_f",    0, 1, SW, E_FOK);
    step("sw_d",    0, 0, SW, E_DEC);
    step("sw_adr",  0, 0, SW, E_MADR);
    step("sw_wait", 0, 0, SW, E_MWRW);
    step("sw_wait", 0, 0, SW, E_MWRW);
    step("sw_done", 0, 1, SW, E_MWRD);

    // beq
    step("beq_f",   0, 1, BEQ, E_FOK);
    step("beq_d",   0, 0, BEQ, E_DEC);
    step("beq_br",  0, 0, BEQ, E_BR);

    // illegal opcode returns to FETCH
    step("ill_f",   0, 1, BAD, E_FOK);
    step("ill_d",   0, 0, BAD, E_DILL);

    // jump opcode
    step("j_f",     0, 1, JOP, E_FOK);
`ifdef J_INSTR_EN
    step("j_d",     0, 0, JOP, E_DEC);
    step("j_jmp",   0, 0, JOP, E_JMP);
`else
    step("j_ill",   0, 0, JOP, E_DILL);
`endif

    // Fetch timeout: 15 waits, BusError on the 16th cycle, then a fresh FETCH
    for (int i = 0; i < 15; i++) step("fto_wait", 0, 0, RT, E_FW);
    step("fto_berr", 0, 0, RT, E_FTO);
    step("fto_refetch", 0, 0, RT, E_FW);
    for (int i = 0; i < 14; i++) step("fto2_wait", 0, 0, RT, E_FW);
    // MemReady on the compare cycle wins over the timeout
    step("fto_race", 0, 1, RT, E_FOK);
    step("race_d",   0, 0, BEQ, E_DEC);
    step("race_br",  0, 0, BEQ, E_BR);

    // sw timeout: MemWrite dropped on the BusError cycle
    step("swto_f",   0, 1, SW, E_FOK);
    step("swto_d",   0, 0, SW, E_DEC);
    step("swto_adr", 0, 0, SW, E_MADR);
    for (int i = 0; i < 15; i++) step("swto_wait", 0, 0, SW, E_MWRW);
    step("swto_berr", 0, 0, SW, E_MWRTO);
    step("swto_fetch", 0, 0, SW, E_FW);

    // Reset in the middle of MEMRD
    step("rr_f",    0, 1, LW, E_FOK);
    step("rr_d",    0, 0, LW, E_DEC);
    step("rr_adr",  0, 0, LW, E_MADR);
    step("rr_rd",   0, 0, LW, E_MRD);
    step("rr_rst",  1, 1, LW, E_RST);
    step("rr_post", 0, 0, LW, E_FW);
    step("rr_f2",   0, 1, RT, E_FOK);
    step("rr_d2",   0, 0, RT, E_DEC);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
